dense_ctrl: RTL and testbench

Control sequencer for fully-connected (DENSE) layers; produces the complete dense-mode control set consumed by the buffer/PE-array mux when comp_sel = 3'b010.
Streams input activations from BUF1 and weights from BUF2 into the PE array, one output neuron per PE, N_PE neurons per group.
Writes each group's N_PE results back to BUF1, then raises done.

---
 rtl/dense_pkg.sv | 20 ++
 rtl/dense_mac_delay.sv | 29 ++
 rtl/dense_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_dense_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/dense_pkg.sv
// Shared types and codes for the dense-layer control sequencer.
package dense_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CLR   = 3'd2,
    ST_READ  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_WRITE = 3'd5,
    ST_DONE  = 3'd6
  } dense_state_t;

  // Mux select code under which this block owns the PE-array controls.
  localparam logic [2:0] COMP_SEL_DENSE = 3'b010;

  localparam logic [1:0] NL_NONE = 2'd0;
  localparam logic [1:0] NL_RELU = 2'd1;

endpackage : dense_pkg

// File: rtl/dense_mac_delay.sv
// Shift register aligning the per-PE MAC mask with buffer read data (DEPTH = read latency).
module dense_mac_delay #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_bypass
    assign q_o = d_i;
  end else begin : g_pipe
    logic [WIDTH-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned k = 0; k < DEPTH; k++) pipe_q[k] <= '0;
      end else begin
        pipe_q[0] <= d_i;
        for (int unsigned k = 1; k < DEPTH; k++) pipe_q[k] <= pipe_q[k-1];
      end
    end

    assign q_o = pipe_q[DEPTH-1];
  end

endmodule : dense_mac_delay

// File: rtl/dense_ctrl.sv
// Dense-layer control sequencer: streams BUF1 activations and BUF2 weights into the PE array.
// Optional nonlinearity control on write-back enabled by defining DENSE_CTRL_NL_EN.
module dense_ctrl
  import dense_pkg::*;
#(
  parameter int unsigned N_PE    = 8,
  parameter int unsigned N_BUF   = 8,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned CNT_W   = 10,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned MAC_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [CNT_W-1:0]        cfg_n_in_i,
  input  logic [CNT_W-1:0]        cfg_n_out_i,
  input  logic [ADDR_W-1:0]       cfg_in_base_i,
  input  logic [ADDR_W-1:0]       cfg_w_base_i,
  input  logic [ADDR_W-1:0]       cfg_out_base_i,
`ifdef DENSE_CTRL_NL_EN
  input  logic                    cfg_nl_en_i,
  input  logic [1:0]              cfg_nl_type_i,
`endif
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    buf1_r_en_o,
  output logic                    buf2_r_en_o,
  output logic [N_BUF*ADDR_W-1:0] buf1_r_addr_o,
  output logic [N_BUF*ADDR_W-1:0] buf2_r_addr_o,
  output logic                    buf1_w_en_o,
  output logic [N_BUF*ADDR_W-1:0] buf1_w_addr_o,
  output logic                    buf2_w_en_o,
  output logic [N_BUF*ADDR_W-1:0] buf2_w_addr_o,
  output logic [N_PE-1:0]         pea_mac_enable_o,
  output logic                    pea_line_buffer_reset_o,
  output logic                    pea_adder_enable_o,
  output logic                    aybz_azby_dense_o,
  output logic                    pea_nl_enable_o,
  output logic [1:0]              pea_nl_type_o
);

  localparam int unsigned WAIT_CYC = RD_LAT + MAC_LAT;
  localparam int unsigned WAIT_W   = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  dense_state_t state_q, state_d;

  logic [CNT_W-1:0]  n_in_q;
  logic [ADDR_W-1:0] in_base_q, out_base_q;
  logic [ADDR_W-1:0] w_ptr_q, w_ptr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  g_q, g_d;
  logic [CNT_W-1:0]  i_q, i_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic              busy_q, busy_d, done_q, done_d;
  logic              r_en_q, r_en_d, w_en_q, w_en_d;
  logic              lbr_q, lbr_d, adder_q, adder_d;
  logic              nl_en_q, nl_en_d;
  logic [1:0]        nl_type_q, nl_type_d;
  logic [ADDR_W-1:0] r1_addr_q, r1_addr_d, r2_addr_q, r2_addr_d, w_addr_q, w_addr_d;
  logic [N_PE-1:0]   rd_mask_q, rd_mask_d, mask_c;

`ifdef DENSE_CTRL_NL_EN
  logic       cfg_nl_en_q;
  logic [1:0] cfg_nl_type_q;
`endif

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      w_ptr_q <= '0;
      rem_q   <= '0;
      g_q     <= '0;
      i_q     <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      w_ptr_q <= w_ptr_d;
      rem_q   <= rem_d;
      g_q     <= g_d;
      i_q     <= i_d;
      wait_q  <= wait_d;
    end
  end

  // Configuration snapshot taken at the end of LOAD; later cfg changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_in_q     <= '0;
      in_base_q  <= '0;
      out_base_q <= '0;
`ifdef DENSE_CTRL_NL_EN
      cfg_nl_en_q   <= 1'b0;
      cfg_nl_type_q <= NL_NONE;
`endif
    end else if (state_q == ST_LOAD) begin
      n_in_q     <= cfg_n_in_i;
      in_base_q  <= cfg_in_base_i;
      out_base_q <= cfg_out_base_i;
`ifdef DENSE_CTRL_NL_EN
      cfg_nl_en_q   <= cfg_nl_en_i;
      cfg_nl_type_q <= cfg_nl_type_i;
`endif
    end
  end

  // Next-state and counter updates
  always_comb begin
    state_d = state_q;
    w_ptr_d = w_ptr_q;
    rem_d   = rem_q;
    g_d     = g_q;
    i_d     = i_q;
    wait_d  = wait_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_LOAD;
      ST_LOAD: begin
        w_ptr_d = cfg_w_base_i;
        rem_d   = cfg_n_out_i;
        g_d     = '0;
        state_d = (cfg_n_in_i == '0 || cfg_n_out_i == '0) ? ST_DONE : ST_CLR;
      end
      ST_CLR: begin
        i_d     = '0;
        state_d = ST_READ;
      end
      ST_READ: begin
        if (i_q == n_in_q - CNT_W'(1)) begin
          wait_d  = '0;
          state_d = ST_WAIT;
        end else begin
          i_d = i_q + CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (wait_q == WAIT_W'(WAIT_CYC - 1)) state_d = ST_WRITE;
        else wait_d = wait_q + WAIT_W'(1);
      end
      ST_WRITE: begin
        // rem_q holds the neurons not yet covered by finished groups
        if (rem_q > CNT_W'(N_PE)) begin
          g_d     = g_q + CNT_W'(1);
          rem_d   = rem_q - CNT_W'(N_PE);
          w_ptr_d = w_ptr_q + ADDR_W'(n_in_q);
          state_d = ST_CLR;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so registered outputs line up with state_q
  always_comb begin
    mask_c = '1;
    if (rem_d < CNT_W'(N_PE)) begin
      for (int unsigned k = 0; k < N_PE; k++) mask_c[k] = (CNT_W'(k) < rem_d);
    end
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    r_en_d    = (state_d == ST_READ);
    w_en_d    = (state_d == ST_WRITE);
    lbr_d     = (state_d == ST_CLR);
    adder_d   = (state_d == ST_WRITE);
    r1_addr_d = r_en_d ? in_base_q + ADDR_W'(i_d) : '0;
    r2_addr_d = r_en_d ? w_ptr_d + ADDR_W'(i_d) : '0;
    w_addr_d  = w_en_d ? out_base_q + ADDR_W'(g_d) : '0;
    rd_mask_d = r_en_d ? mask_c : '0;
`ifdef DENSE_CTRL_NL_EN
    nl_en_d   = w_en_d & cfg_nl_en_q;
    nl_type_d = w_en_d ? cfg_nl_type_q : NL_NONE;
`else
    nl_en_d   = 1'b0;
    nl_type_d = NL_NONE;
`endif
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      r_en_q    <= 1'b0;
      w_en_q    <= 1'b0;
      lbr_q     <= 1'b0;
      adder_q   <= 1'b0;
      nl_en_q   <= 1'b0;
      nl_type_q <= NL_NONE;
      r1_addr_q <= '0;
      r2_addr_q <= '0;
      w_addr_q  <= '0;
      rd_mask_q <= '0;
    end else begin
      busy_q    <= busy_d;
      done_q    <= done_d;
      r_en_q    <= r_en_d;
      w_en_q    <= w_en_d;
      lbr_q     <= lbr_d;
      adder_q   <= adder_d;
      nl_en_q   <= nl_en_d;
      nl_type_q <= nl_type_d;
      r1_addr_q <= r1_addr_d;
      r2_addr_q <= r2_addr_d;
      w_addr_q  <= w_addr_d;
      rd_mask_q <= rd_mask_d;
    end
  end

  dense_mac_delay #(
    .DEPTH (RD_LAT),
    .WIDTH (N_PE)
  ) u_mac_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rd_mask_q),
    .q_o   (pea_mac_enable_o)
  );

  assign busy_o                  = busy_q;
  assign done_o                  = done_q;
  assign buf1_r_en_o             = r_en_q;
  assign buf2_r_en_o             = r_en_q;
  assign buf1_r_addr_o           = {N_BUF{r1_addr_q}};
  assign buf2_r_addr_o           = {N_BUF{r2_addr_q}};
  assign buf1_w_en_o             = w_en_q;
  assign buf1_w_addr_o           = {N_BUF{w_addr_q}};
  assign buf2_w_en_o             = 1'b0;
  assign buf2_w_addr_o           = '0;
  assign pea_line_buffer_reset_o = lbr_q;
  assign pea_adder_enable_o      = adder_q;
  assign aybz_azby_dense_o       = busy_q;
  assign pea_nl_enable_o         = nl_en_q;
  assign pea_nl_type_o           = nl_type_q;

endmodule : dense_ctrl

// File: tb/tb_dense_ctrl.sv
// Testbench for dense_ctrl: per-cycle comparison against a schedule-level reference model.
module tb_dense_ctrl;

  localparam int unsigned N_PE    = 8;
  localparam int unsigned N_BUF   = 8;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned CNT_W   = 10;
  localparam int unsigned RD_LAT  = 1;
  localparam int unsigned MAC_LAT = 1;
  localparam int          AMOD    = 1 << ADDR_W;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    start_i;
  logic [CNT_W-1:0]        cfg_n_in_i, cfg_n_out_i;
  logic [ADDR_W-1:0]       cfg_in_base_i, cfg_w_base_i, cfg_out_base_i;
  logic                    cfg_nl_en_i;
  logic [1:0]              cfg_nl_type_i;
  logic                    busy_o, done_o, buf1_r_en_o, buf2_r_en_o, buf1_w_en_o, buf2_w_en_o;
  logic [N_BUF*ADDR_W-1:0] buf1_r_addr_o, buf2_r_addr_o, buf1_w_addr_o, buf2_w_addr_o;
  logic [N_PE-1:0]         pea_mac_enable_o;
  logic                    pea_line_buffer_reset_o, pea_adder_enable_o, aybz_azby_dense_o;
  logic                    pea_nl_enable_o;
  logic [1:0]              pea_nl_type_o;

  always #5 clk = ~clk;

  dense_ctrl #(
    .N_PE(N_PE), .N_BUF(N_BUF), .ADDR_W(ADDR_W), .CNT_W(CNT_W),
    .RD_LAT(RD_LAT), .MAC_LAT(MAC_LAT)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .start_i                 (start_i),
    .cfg_n_in_i              (cfg_n_in_i),
    .cfg_n_out_i             (cfg_n_out_i),
    .cfg_in_base_i           (cfg_in_base_i),
    .cfg_w_base_i            (cfg_w_base_i),
    .cfg_out_base_i          (cfg_out_base_i),
`ifdef DENSE_CTRL_NL_EN
    .cfg_nl_en_i             (cfg_nl_en_i),
    .cfg_nl_type_i           (cfg_nl_type_i),
`endif
    .busy_o                  (busy_o),
    .done_o                  (done_o),
    .buf1_r_en_o             (buf1_r_en_o),
    .buf2_r_en_o             (buf2_r_en_o),
    .buf1_r_addr_o           (buf1_r_addr_o),
    .buf2_r_addr_o           (buf2_r_addr_o),
    .buf1_w_en_o             (buf1_w_en_o),
    .buf1_w_addr_o           (buf1_w_addr_o),
    .buf2_w_en_o             (buf2_w_en_o),
    .buf2_w_addr_o           (buf2_w_addr_o),
    .pea_mac_enable_o        (pea_mac_enable_o),
    .pea_line_buffer_reset_o (pea_line_buffer_reset_o),
    .pea_adder_enable_o      (pea_adder_enable_o),
    .aybz_azby_dense_o       (aybz_azby_dense_o),
    .pea_nl_enable_o         (pea_nl_enable_o),
    .pea_nl_type_o           (pea_nl_type_o)
  );

  // Expected outputs for one clock cycle
  typedef struct packed {
    bit              busy, done, ren, wen, lbr, adder, nl_en;
    bit [1:0]        nl_type;
    bit [ADDR_W-1:0] a1, a2, wa;
    bit [N_PE-1:0]   rdmask, mac;
  } rec_t;

  rec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic compare(input rec_t r);
    chk("ctl",
        128'({busy_o, done_o, buf1_r_en_o, buf2_r_en_o, buf1_w_en_o, buf2_w_en_o,
              pea_line_buffer_reset_o, pea_adder_enable_o, aybz_azby_dense_o,
              pea_nl_enable_o, pea_nl_type_o}),
        128'({r.busy, r.done, r.ren, r.ren, r.wen, 1'b0, r.lbr, r.adder, r.busy,
              r.nl_en, r.nl_type}));
    chk("buf1_r_addr", 128'(buf1_r_addr_o), 128'({N_BUF{r.a1}}));
    chk("buf2_r_addr", 128'(buf2_r_addr_o), 128'({N_BUF{r.a2}}));
    chk("buf1_w_addr", 128'(buf1_w_addr_o), 128'({N_BUF{r.wa}}));
    chk("buf2_w_addr", 128'(buf2_w_addr_o), 128'(0));
    chk("mac_enable",  128'(pea_mac_enable_o), 128'(r.mac));
  endtask

  // Reference schedule: LOAD, per group CLR/READ*n_in/WAIT*(RD+MAC)/WRITE, DONE, then idle
  task automatic build(input int n_in, input int n_out, input int in_b, input int w_b,
                       input int out_b, input bit nle, input bit [1:0] nlt);
    rec_t r;
    int   groups, rem;
    exp_q.delete();
    r = '0; r.busy = 1'b1; exp_q.push_back(r);
    if (n_in != 0 && n_out != 0) begin
      groups = (n_out + N_PE - 1) / N_PE;
      for (int g = 0; g < groups; g++) begin
        rem = n_out - g * N_PE;
        r = '0; r.busy = 1'b1; r.lbr = 1'b1; exp_q.push_back(r);
        for (int i = 0; i < n_in; i++) begin
          r = '0; r.busy = 1'b1; r.ren = 1'b1;
          r.a1 = ADDR_W'((in_b + i) % AMOD);
          r.a2 = ADDR_W'((w_b + g * n_in + i) % AMOD);
          r.rdmask = (rem >= N_PE) ? {N_PE{1'b1}} : N_PE'((1 << rem) - 1);
          exp_q.push_back(r);
        end
        for (int w = 0; w < RD_LAT + MAC_LAT; w++) begin
          r = '0; r.busy = 1'b1; exp_q.push_back(r);
        end
        r = '0; r.busy = 1'b1; r.wen = 1'b1; r.adder = 1'b1;
        r.wa = ADDR_W'((out_b + g) % AMOD);
`ifdef DENSE_CTRL_NL_EN
        r.nl_en = nle; r.nl_type = nlt;
`endif
        exp_q.push_back(r);
      end
    end
    r = '0; r.busy = 1'b1; r.done = 1'b1; exp_q.push_back(r);
    r = '0; exp_q.push_back(r);
    for (int t = 0; t < exp_q.size(); t++) begin
      r = exp_q[t];
      r.mac = (t >= RD_LAT) ? exp_q[t - RD_LAT].rdmask : '0;
      exp_q[t] = r;
    end
  endtask

  // Runs one job from posedge+1; repulse pulses start again at that index, abort stops early
  task automatic run(input int n_in, input int n_out, input int in_b, input int w_b,
                     input int out_b, input bit nle, input bit [1:0] nlt,
                     input int repulse, input int abort_at);
    build(n_in, n_out, in_b, w_b, out_b, nle, nlt);
    cfg_n_in_i = CNT_W'(n_in);       cfg_n_out_i    = CNT_W'(n_out);
    cfg_in_base_i = ADDR_W'(in_b);   cfg_w_base_i   = ADDR_W'(w_b);
    cfg_out_base_i = ADDR_W'(out_b); cfg_nl_en_i    = nle;
    cfg_nl_type_i = nlt;             start_i        = 1'b1;
    @(posedge clk); #1; start_i = 1'b0;
    for (int t = 0; t < exp_q.size(); t++) begin
      cyc = t + 1;
      @(negedge clk);
      compare(exp_q[t]);
      @(posedge clk); #1;
      if (t == 0) begin
        cfg_n_in_i = CNT_W'($urandom);     cfg_n_out_i   = CNT_W'($urandom);
        cfg_in_base_i = ADDR_W'($urandom); cfg_w_base_i  = ADDR_W'($urandom);
        cfg_out_base_i = ADDR_W'($urandom);
        cfg_nl_en_i = 1'(~nle);            cfg_nl_type_i = 2'($urandom);
      end
      start_i = (t + 1 == repulse);
      if (t == abort_at) break;
    end
    start_i = 1'b0;
  endtask

  initial begin
    rec_t zero;
    int   ni, no;
    zero = '0;
    rst_n = 1'b0; start_i = 1'b0;
    cfg_n_in_i = '0; cfg_n_out_i = '0; cfg_in_base_i = '0; cfg_w_base_i = '0;
    cfg_out_base_i = '0; cfg_nl_en_i = 1'b0; cfg_nl_type_i = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk); compare(zero);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk); compare(zero);
    @(posedge clk); #1;

    run(3, 10, 0, 100, 200, 1'b0, 2'd0, -1, -1);
    run(0, 5, 10, 20, 30, 1'b0, 2'd0, -1, -1);
    run(5, 8, 40, 50, 60, 1'b0, 2'd0, -1, -1);
    run(4, 3, 1022, 1021, 1023, 1'b0, 2'd0, -1, -1);
    run(2, 17, 7, 1020, 1022, 1'b1, 2'd1, -1, -1);
    run(6, 12, 300, 400, 500, 1'b0, 2'd0, 4, -1);

    // Reset asserted in the middle of READ: outputs clear at once, no done pulse
    run(6, 12, 300, 400, 500, 1'b0, 2'd0, -1, 4);
    rst_n = 1'b0;
    #1; compare(zero);
    @(negedge clk); compare(zero);
    @(posedge clk); #1; rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); compare(zero);
      @(posedge clk); #1;
    end
    run(3, 9, 11, 22, 33, 1'b1, 2'd1, -1, -1);

    for (int n = 0; n < 20; n++) begin
      ni = (n % 7 == 6) ? 0 : int'($urandom_range(1, 12));
      no = (n % 9 == 8) ? 0 : int'($urandom_range(1, 30));
      run(ni, no, int'($urandom_range(0, AMOD - 1)), int'($urandom_range(0, AMOD - 1)),
          int'($urandom_range(0, AMOD - 1)), 1'($urandom), 2'($urandom), -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_dense_ctrl
